// File: rtl/conv3x3_ctrl.sv
// rtl/conv3x3_ctrl.sv - line-buffer sequencer and result tagger for the 3x3 sharpen convolution
module conv3x3_ctrl #(
   parameter int WIDTH    = 320,
   parameter int HEIGHT   = 240,
   parameter int PIPE_LAT = 9,
   parameter int DROP     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic        i_valid,
   input  logic [7:0]  i_pixel,
   output logic        o_ready,
   output logic        conv_valid,
   output logic        conv_done,
   output logic [23:0] conv_data,
   input  logic [34:0] conv_o_data,
   output logic        o_valid,
   output logic [7:0]  o_data,
   output logic        o_last,
   output logic        o_busy,
   output logic        o_frame_done
);
   localparam int BLEN = WIDTH + PIPE_LAT;
   localparam int CW   = $clog2(WIDTH);
   localparam int RW   = $clog2(HEIGHT);
   localparam int BW   = $clog2(BLEN);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;
   state_t r_state, w_next;

   logic [7:0]          r_lbuf [4][WIDTH];
   logic [CW-1:0]       r_col;
   logic [RW-1:0]       r_row;
   logic [1:0]          r_wptr;
   logic                r_bact;
   logic [BW-1:0]       r_bcol;
   logic [1:0]          r_bbuf;
   logic                r_bfinal;
   logic                r_qpend;
   logic [1:0]          r_qbuf;
   logic                r_qfinal;
   logic [PIPE_LAT-1:0] r_tag_real;
   logic [PIPE_LAT-1:0] r_tag_keep;
   logic [PIPE_LAT-1:0] r_tag_last;
   logic                r_o_valid;
   logic                r_o_last;
   logic [7:0]          r_o_data;
   logic                r_frame_done;

   logic                w_accept;
   logic                w_row_end;
   logic                w_frame_end;
   logic                w_burst_req;
   logic                w_burst_end;
   logic                w_free;
   logic [CW-1:0]       w_rcol;
   logic                w_keep;
   logic                w_last_col;
   logic [7:0]          w_clamp;

   // A queued burst means the next row would overwrite a buffer still being read, so input stalls.
   assign o_ready     = ((r_state == S_FILL) || (r_state == S_RUN)) && !r_qpend;
   assign o_busy      = (r_state != S_IDLE);
   assign w_accept    = i_valid && o_ready;
   assign w_row_end   = w_accept && (r_col == CW'(WIDTH - 1));
   assign w_frame_end = w_row_end && (r_row == RW'(HEIGHT - 1));
   assign w_burst_req = w_row_end && (r_row >= RW'(2));
   assign w_burst_end = r_bact && (r_bcol == BW'(BLEN - 1));
   assign w_free      = !r_bact || w_burst_end;

   // Flush cycles past the row end keep presenting the last column.
   assign w_rcol      = (r_bcol >= BW'(WIDTH - 1)) ? CW'(WIDTH - 1) : r_bcol[CW-1:0];
   assign w_keep      = (r_bcol >= BW'(DROP)) && (r_bcol < BW'(WIDTH));
   assign w_last_col  = r_bfinal && (r_bcol == BW'(WIDTH - 1));

   assign conv_valid  = r_bact;
   assign conv_done   = r_bact && w_last_col;
   assign conv_data   = r_bact ? {r_lbuf[r_bbuf - 2'd2][w_rcol],
                                  r_lbuf[r_bbuf - 2'd1][w_rcol],
                                  r_lbuf[r_bbuf][w_rcol]} : 24'd0;

   assign w_clamp     = conv_o_data[34] ? 8'd0 :
                        (|conv_o_data[33:8]) ? 8'd255 : conv_o_data[7:0];

   assign o_valid      = r_o_valid;
   assign o_data       = r_o_data;
   assign o_last       = r_o_last;
   assign o_frame_done = r_frame_done;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Frame sequencing: fill two rows, run bursts, then drain until the last result leaves.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_FILL;
         S_FILL:  if (w_row_end && (r_row == RW'(1))) w_next = S_RUN;
         S_RUN:   if (w_frame_end) w_next = S_DRAIN;
         S_DRAIN: if (r_o_valid && r_o_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Raster position and rotating write buffer, cleared while idle.
   always_ff @(posedge clk) begin
      if (reset || (r_state == S_IDLE)) begin
         r_col  <= '0;
         r_row  <= '0;
         r_wptr <= 2'd0;
      end else if (w_accept) begin
         if (w_row_end) begin
            r_col  <= '0;
            r_row  <= r_row + RW'(1);
            r_wptr <= r_wptr + 2'd1;
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Line buffer write port.
   always_ff @(posedge clk) begin
      if (w_accept) r_lbuf[r_wptr][r_col] <= i_pixel;
   end

   // Burst launcher with a single-entry queue; a freeing burst hands over without a gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bact   <= 1'b0;
         r_bcol   <= '0;
         r_bbuf   <= 2'd0;
         r_bfinal <= 1'b0;
         r_qpend  <= 1'b0;
         r_qbuf   <= 2'd0;
         r_qfinal <= 1'b0;
      end else if (w_free) begin
         r_bcol <= '0;
         if (r_qpend) begin
            r_bact   <= 1'b1;
            r_bbuf   <= r_qbuf;
            r_bfinal <= r_qfinal;
            r_qpend  <= 1'b0;
         end else if (w_burst_req) begin
            r_bact   <= 1'b1;
            r_bbuf   <= r_wptr;
            r_bfinal <= w_frame_end;
         end else begin
            r_bact <= 1'b0;
         end
      end else begin
         r_bcol <= r_bcol + BW'(1);
         if (w_burst_req) begin
            r_qpend  <= 1'b1;
            r_qbuf   <= r_wptr;
            r_qfinal <= w_frame_end;
         end
      end
   end

   // Tag pipeline aligned to the convolution latency; kept results are clamped at the tap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag_real   <= '0;
         r_tag_keep   <= '0;
         r_tag_last   <= '0;
         r_o_valid    <= 1'b0;
         r_o_last     <= 1'b0;
         r_o_data     <= 8'd0;
         r_frame_done <= 1'b0;
      end else begin
         r_tag_real <= {r_tag_real[PIPE_LAT-2:0], r_bact};
         r_tag_keep <= {r_tag_keep[PIPE_LAT-2:0], r_bact && w_keep};
         r_tag_last <= {r_tag_last[PIPE_LAT-2:0], r_bact && w_last_col};
         if (r_tag_real[PIPE_LAT-1] && r_tag_keep[PIPE_LAT-1]) begin
            r_o_valid <= 1'b1;
            r_o_data  <= w_clamp;
            r_o_last  <= r_tag_last[PIPE_LAT-1];
         end else begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
         end
         r_frame_done <= (r_state == S_DRAIN) && r_o_valid && r_o_last;
      end
   end
endmodule

// File: tb/tb_conv3x3_ctrl.sv
// tb/tb_conv3x3_ctrl.sv - randomized frame bench for conv3x3_ctrl against a sharpen image model
module tb_conv3x3_ctrl;
   localparam int W    = 10;
   localparam int H    = 7;
   localparam int P    = 9;
   localparam int BLEN = W + P;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_start;
   logic        i_valid;
   logic [7:0]  i_pixel;
   logic        o_ready;
   logic        conv_valid;
   logic        conv_done;
   logic [23:0] conv_data;
   logic [34:0] conv_o_data = '0;
   logic        o_valid;
   logic [7:0]  o_data;
   logic        o_last;
   logic        o_busy;
   logic        o_frame_done;

   conv3x3_ctrl #(.WIDTH(W), .HEIGHT(H), .PIPE_LAT(P), .DROP(2)) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .i_valid(i_valid), .i_pixel(i_pixel),
      .o_ready(o_ready), .conv_valid(conv_valid), .conv_done(conv_done), .conv_data(conv_data),
      .conv_o_data(conv_o_data), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
      .o_busy(o_busy), .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int img [W*H];
   int exp_q [$];
   int out_q [$];
   int conv_pipe [$];
   int cv_frame, cv_run, done_cnt, nruns, last_run, first_cv_cyc, acc_cyc;
   bit prev_last;
   logic [23:0] ca = '0;
   logic [23:0] cb = '0;

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic int clampi(input int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   // Golden output: sharpen of every interior pixel, raster order.
   task automatic build_exp();
      int v;
      exp_q.delete();
      out_q.delete();
      for (int r = 1; r <= H-2; r++) begin
         for (int x = 1; x <= W-2; x++) begin
            v = 5*img[r*W+x] - img[(r-1)*W+x] - img[(r+1)*W+x] - img[r*W+x-1] - img[r*W+x+1];
            exp_q.push_back(clampi(v));
         end
      end
   endtask

   always @(posedge clk) cyc++;

   // Stand-in convolution: sliding 3-column window, result delayed P cycles.
   always @(negedge clk) begin
      int r;
      r = 0;
      if (conv_valid) begin
         r = 5*int'(cb[15:8]) - int'(cb[23:16]) - int'(cb[7:0]) - int'(ca[15:8]) - int'(conv_data[15:8]);
         ca = cb;
         cb = conv_data;
      end
      conv_pipe.push_back(r);
      if (conv_pipe.size() > P) conv_o_data = 35'(conv_pipe.pop_front());
   end

   // Output and burst-shape monitor.
   always @(negedge clk) begin
      int e;
      if (reset) begin
         prev_last = 1'b0;
         cv_run    = 0;
      end else begin
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_o_valid", int'(o_data), -1);
            end else begin
               e = exp_q.pop_front();
               check("o_data", int'(o_data), e);
               check("o_last", int'(o_last), int'(exp_q.size() == 0));
               out_q.push_back(int'(o_data));
            end
         end
         if (prev_last || o_frame_done) check("frame_done_timing", int'(o_frame_done), int'(prev_last));
         prev_last = o_valid && o_last;
         if (conv_valid) begin
            if (first_cv_cyc < 0) first_cv_cyc = cyc;
            cv_run++;
            cv_frame++;
         end else if (cv_run > 0) begin
            check("burst_len", cv_run % BLEN, 0);
            last_run = cv_run;
            nruns++;
            cv_run = 0;
         end
         if (conv_done) done_cnt++;
      end
   end

   task automatic check_zero();
      check("zero_ctrl", int'({o_ready, conv_valid, conv_done, o_valid, o_last, o_busy, o_frame_done}), 0);
      check("zero_conv_data", int'(conv_data), 0);
      check("zero_o_data", int'(o_data), 0);
   endtask

   task automatic run_frame(input int prob, input int start_at, input int rst_at, input bit timing);
      int idx, guard, got;
      build_exp();
      cv_frame = 0; done_cnt = 0; nruns = 0; last_run = 0; first_cv_cyc = -1; acc_cyc = -1;
      i_start = 1'b1;
      @(negedge clk);
      check("ready_in_start_cycle", int'(o_ready), 0);
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      check("ready_after_start", int'(o_ready), 1);
      check("busy_after_start", int'(o_busy), 1);
      @(posedge clk); #1;
      idx = 0;
      guard = 0;
      while (idx < W*H && guard < 5000 && !(rst_at >= 0 && cv_frame >= rst_at)) begin
         i_start = (idx == start_at);
         i_valid = (int'($urandom_range(99)) < prob);
         i_pixel = 8'(img[idx]);
         @(negedge clk);
         if (i_valid && o_ready) begin
            if (idx == 3*W-1) acc_cyc = cyc;
            idx++;
         end
         guard++;
         @(posedge clk); #1;
      end
      i_start = 1'b0;
      i_valid = 1'b0;
      if (rst_at >= 0) begin
         guard = 0;
         while (cv_frame < rst_at && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
         end
         check("reset_point_reached", int'(cv_frame >= rst_at), 1);
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         exp_q.delete();
         @(negedge clk);
         check_zero();
         repeat (40) @(posedge clk);
         #1;
      end else begin
         check("feed_done", idx, W*H);
         i_valid = 1'b1;
         i_pixel = 8'd77;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ready_low_drain", int'(o_ready), 0);
            @(posedge clk); #1;
         end
         i_valid = 1'b0;
         guard = 0;
         got = 0;
         while (got == 0 && guard < 3000) begin
            @(negedge clk);
            if (o_frame_done) got = 1;
            guard++;
         end
         check("frame_done_seen", got, 1);
         check("outputs_left", exp_q.size(), 0);
         check("output_count", out_q.size(), 40);
         check("conv_done_count", done_cnt, 1);
         @(posedge clk); #1;
         i_valid = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("busy_low_idle", int'(o_busy), 0);
            check("ready_low_idle", int'(o_ready), 0);
            @(posedge clk); #1;
         end
         i_valid = 1'b0;
         if (timing) begin
            check("first_burst_cycle", first_cv_cyc, acc_cyc + 1);
            check("burst_run_len", last_run, 95);
            check("burst_runs", nruns, 1);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_pixel = 8'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_zero();
      @(posedge clk); #1;

      for (int i = 0; i < W*H; i++) img[i] = 10;
      run_frame(100, -1, -1, 1'b1);
      n = 0;
      foreach (out_q[i]) if (out_q[i] == 10) n++;
      check("const10_values", n, 40);

      for (int i = 0; i < W*H; i++) img[i] = 0;
      img[3*W+4] = 255;
      run_frame(100, -1, -1, 1'b0);
      check("clampA_centre", out_q[19], 255);
      check("clampA_left",   out_q[18], 0);
      check("clampA_right",  out_q[20], 0);
      check("clampA_up",     out_q[11], 0);
      check("clampA_down",   out_q[27], 0);

      for (int i = 0; i < W*H; i++) img[i] = 0;
      img[3*W+4] = 200;
      img[2*W+4] = 255; img[4*W+4] = 255; img[3*W+3] = 255; img[3*W+5] = 255;
      run_frame(100, -1, -1, 1'b0);
      check("clampB_centre", out_q[19], 0);
      check("clampB_up",     out_q[11], 255);

      for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(255));
      run_frame(30, 4*W, -1, 1'b0);

      for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(255));
      run_frame(100, -1, 3*BLEN + 5, 1'b0);

      for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(255));
      run_frame(60, -1, -1, 1'b0);

      for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(255));
      run_frame(100, -1, -1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/conv3x3_ctrl.md
# conv3x3_ctrl

Frame sequencer and line-buffer controller for the 3x3 sharpen convolution. It accepts a raster pixel stream and stores rows in four rotating line buffers. For each output row it bursts packed 3-row columns into the convolution with `conv_valid` held high for the whole burst. It then tracks results with its own tag pipeline and emits saturated 8-bit pixels for the valid (HEIGHT-2)x(WIDTH-2) region. The convolution's own valid/done outputs are not used, because its valid stage latches high after the first input.

## Interface
- `WIDTH`, 320: pixels per row (>= 4).
- `HEIGHT`, 240: rows per frame (>= 3).
- `PIPE_LAT`, 9: cycles from a column on `conv_data` to its result on `conv_o_data`.
- `DROP`, 2: leading results discarded per burst (window priming).

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `i_start` in 1: frame start pulse; honoured only in IDLE.
- `i_valid` in 1: pixel valid; a transfer occurs when `i_valid && o_ready`.
- `i_pixel` in 8: unsigned luma.
- `o_ready` out 1: controller accepts a pixel this cycle.
- `conv_valid` out 1: column valid to the convolution.
- `conv_done` out 1: high on the last real column of the frame.
- `conv_data` out 24: {row r-2, row r-1, row r} pixels of one column.
- `conv_o_data` in 35: signed convolution result.
- `o_valid` out 1: output pixel valid.
- `o_data` out 8: result clamped to 0..255.
- `o_last` out 1: with `o_valid`, last pixel of the frame.
- `o_busy` out 1: frame in progress.
- `o_frame_done` out 1: one-cycle pulse after the last output.

## Operation
- **Reset values:** all outputs are 0; the FSM is in IDLE, buffer pointers are 0, and the tag pipeline is cleared.
- **Reset mid-frame:** the same state is forced on the next edge; in-flight results are discarded and no `o_valid` is issued for them.
- **FSM states:**
  - IDLE → FILL on `i_start`; `o_busy` goes high.
  - FILL: accepts rows 0 and 1 with no bursts; → RUN when row 1 completes.
  - RUN: accepts rows 2..HEIGHT-1. On completion of row k (k >= 2), a burst over rows k-2, k-1, k is queued.
  - When all HEIGHT rows are accepted: `o_ready` drops; → DRAIN.
  - DRAIN: waits for the last burst and the tag pipeline to empty, pulses `o_frame_done`, then → IDLE.
- **Line buffers:** 4 × WIDTH × 8 bits. The write pointer advances modulo 4 per completed row. The three read buffers are the rows k-2, k-1, k relative to the burst row; they are never the buffer being written.
- **Burst:**
  - WIDTH + PIPE_LAT consecutive cycles with `conv_valid = 1`. No bubbles are allowed.
  - Cycles 0..WIDTH-1 carry columns 0..WIDTH-1.
  - The remaining PIPE_LAT cycles repeat column WIDTH-1 as flush.
  - `conv_done` is high on column WIDTH-1 of the final burst only.
- **Burst scheduling:**
  - A queued burst starts the cycle after the previous burst ends, or the cycle after queueing if none is active.
  - Writing of row k+1 proceeds during the burst of row k.
  - At most one burst is queued. If row k+1 completes while the burst of row k is still active and one burst is already queued, `o_ready` is held low until the queue frees.
- **Tag pipeline:**
  - A PIPE_LAT-deep shift register, advanced every cycle, carrying {real, keep, last} per launched column.
  - `keep` = column index >= DROP and column < WIDTH.
  - `last` = final kept column of the final burst.
  - At the tap, if `real && keep`, `conv_o_data` is clamped and registered: negative → 0, > 255 → 255, else bits [7:0].
- **Output count:** (WIDTH-DROP) × (HEIGHT-2) `o_valid` pulses per frame, in raster order.

## Timing
- `o_ready` rises 1 cycle after `i_start` in IDLE.
- First burst: starts 1 cycle after the accept of pixel (row 2, column WIDTH-1).
- Column c of a burst is on `conv_data` at burst cycle c.
- Output for column c: `o_valid` at burst cycle c + PIPE_LAT + 1.
- `o_frame_done` pulses 1 cycle after the `o_valid` carrying `o_last`.
- With a 1 pixel/cycle input, bursts run back-to-back with zero idle cycles between them.
- `i_start` in a non-IDLE state is ignored.
- `i_valid` while `o_ready = 0` is ignored; the data is not consumed.

## Test plan
- 6x4 frame (WIDTH=6, HEIGHT=4), constant pixel 10, continuous input:
  - 8 `o_valid` pulses, each `o_data = 10`.
  - `o_last` on the 8th, then `o_frame_done`.
- Clamping, WIDTH=6 / HEIGHT=3:
  - Single 255 pixel centred, zeros elsewhere → 255 at its position, 0 at its neighbours.
  - Single 200 pixel with 255 neighbours → 0.
- Throughput with default parameters, continuous input:
  - `conv_valid` is never low between the first and last burst.
  - Exactly 318 × 238 outputs.
- Throttled input, `i_valid` random at 30%:
  - Output values match the golden model.
  - `conv_valid` has no gaps inside any burst.
- Reset in mid-burst of row 5:
  - All outputs are 0 the next cycle.
  - A new `i_start` frame produces the correct full output.
- Illegal accesses:
  - `i_start` during RUN → no effect.
  - `i_valid` after HEIGHT rows → `o_ready = 0` and no extra row is written.
